// File: rtl/usb_bit_stuffer_hs_if.sv
// rtl/usb_bit_stuffer_hs_if.sv - serialiser-side and encoder-side bit handshakes of the bit stuffer
interface usb_bit_stuffer_hs_if;
    logic in_bit;
    logic in_valid;
    logic in_ready;
    logic out_bit;
    logic out_valid;
    logic out_ready;
    logic out_stuff;

    modport master (
        output in_bit, in_valid, out_ready,
        input  in_ready, out_bit, out_valid, out_stuff
    );

    modport slave (
        input  in_bit, in_valid, out_ready,
        output in_ready, out_bit, out_valid, out_stuff
    );
endinterface

// File: rtl/usb_bit_stuffer_hs.sv
// rtl/usb_bit_stuffer_hs.sv - handshaked bit stuffer inserting a zero after MAX_RUN ones
// Stuff-event counter present only when USB_BIT_STUFFER_CNT_EN is defined.
module usb_bit_stuffer_hs #(
    parameter int MAX_RUN = 6,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               clr,
    usb_bit_stuffer_hs_if.slave bus,
    output logic [CNT_W-1:0]   stuff_count
);

    localparam int RUN_W = $clog2(MAX_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_STUFF = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             out_bit_q, out_bit_d;
    logic             out_valid_q, out_valid_d;
    logic             out_stuff_q, out_stuff_d;

    logic slot_free;
    logic accept;
    logic stuff_load;

    assign slot_free     = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = (state_q == S_RUN) && slot_free && !clr;
    assign accept        = bus.in_valid && bus.in_ready;
    // clr discards a pending stuff bit, so it must also block its load
    assign stuff_load    = (state_q == S_STUFF) && slot_free && !clr;

    assign bus.out_bit   = out_bit_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_stuff = out_stuff_q;

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        out_bit_d   = out_bit_q;
        out_valid_d = out_valid_q;
        out_stuff_d = out_stuff_q;

        if (slot_free) begin
            out_valid_d = 1'b0;
            if (stuff_load) begin
                out_bit_d   = 1'b0;
                out_valid_d = 1'b1;
                out_stuff_d = 1'b1;
                state_d     = S_RUN;
            end else if (accept) begin
                out_bit_d   = bus.in_bit;
                out_valid_d = 1'b1;
                out_stuff_d = 1'b0;
                if (bus.in_bit) begin
                    if (run_q + RUN_W'(1) == RUN_MAX) begin
                        run_d   = '0;
                        state_d = S_STUFF;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end else begin
                    run_d = '0;
                end
            end
        end

        if (clr) begin
            run_d   = '0;
            state_d = S_RUN;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q     <= S_RUN;
            run_q       <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_stuff_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            out_stuff_q <= out_stuff_d;
        end
    end

`ifdef USB_BIT_STUFFER_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (stuff_load && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stuff_count = cnt_q;
`else
    assign stuff_count = '0;
`endif

endmodule

// File: tb/tb_usb_bit_stuffer_hs.sv
// tb/tb_usb_bit_stuffer_hs.sv - scoreboard bench for usb_bit_stuffer_hs (MAX_RUN 6 and 3 instances)
module tb_usb_bit_stuffer_hs;

`ifdef USB_BIT_STUFFER_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        clr6, clr3;
    logic [15:0] cnt6, cnt3;

    int checks   = 0;
    int failures = 0;

    logic [1:0] q6[$];
    logic [1:0] q3[$];
    logic [1:0] e6, e3;
    int run6 = 0, run3 = 0;
    int stuffs6 = 0, stuffs3 = 0;
    int outs6 = 0, outs3 = 0;

    usb_bit_stuffer_hs_if b6();
    usb_bit_stuffer_hs_if b3();

    usb_bit_stuffer_hs #(.MAX_RUN(6), .CNT_W(16)) u_dut6 (
        .clk(clk), .RST(rst), .clr(clr6), .bus(b6), .stuff_count(cnt6)
    );

    usb_bit_stuffer_hs #(.MAX_RUN(3), .CNT_W(16)) u_dut3 (
        .clk(clk), .RST(rst), .clr(clr3), .bus(b3), .stuff_count(cnt3)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && b6.out_valid === 1'b1 && b6.out_ready === 1'b1) begin
            outs6++;
            checks++;
            if (q6.size() == 0) begin
                failures++;
                $display("FAIL mon6_unexpected got bit=%b stuff=%b required no output", b6.out_bit, b6.out_stuff);
            end else begin
                e6 = q6.pop_front();
                if ({b6.out_bit, b6.out_stuff} !== e6) begin
                    failures++;
                    $display("FAIL mon6_data got bit,stuff=%b required %b", {b6.out_bit, b6.out_stuff}, e6);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b3.out_valid === 1'b1 && b3.out_ready === 1'b1) begin
            outs3++;
            checks++;
            if (q3.size() == 0) begin
                failures++;
                $display("FAIL mon3_unexpected got bit=%b stuff=%b required no output", b3.out_bit, b3.out_stuff);
            end else begin
                e3 = q3.pop_front();
                if ({b3.out_bit, b3.out_stuff} !== e3) begin
                    failures++;
                    $display("FAIL mon3_data got bit,stuff=%b required %b", {b3.out_bit, b3.out_stuff}, e3);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic model6(input logic b);
        q6.push_back({b, 1'b0});
        if (b) begin
            run6++;
            if (run6 == 6) begin
                run6 = 0;
                q6.push_back(2'b01);
                stuffs6++;
            end
        end else begin
            run6 = 0;
        end
    endtask

    task automatic model3(input logic b);
        q3.push_back({b, 1'b0});
        if (b) begin
            run3++;
            if (run3 == 3) begin
                run3 = 0;
                q3.push_back(2'b01);
                stuffs3++;
            end
        end else begin
            run3 = 0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send6(input logic b, output int stall);
        bit done = 1'b0;
        stall = 0;
        b6.in_bit   = b;
        b6.in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (b6.in_ready === 1'b1) begin
                model6(b);
                done = 1'b1;
            end else begin
                stall++;
                if (stall > 20) begin
                    checks++;
                    failures++;
                    $display("FAIL send6_timeout got in_ready=0 for %0d cycles required accept", stall);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        b6.in_valid = 1'b0;
    endtask

    task automatic send3(input logic b, output int stall);
        bit done = 1'b0;
        stall = 0;
        b3.in_bit   = b;
        b3.in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (b3.in_ready === 1'b1) begin
                model3(b);
                done = 1'b1;
            end else begin
                stall++;
                if (stall > 20) begin
                    checks++;
                    failures++;
                    $display("FAIL send3_timeout got in_ready=0 for %0d cycles required accept", stall);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        b3.in_valid = 1'b0;
    endtask

    task automatic drain6();
        int n = 0;
        while ((q6.size() != 0 || b6.out_valid !== 1'b0) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (q6.size() != 0 || b6.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain6 got %0d pending, out_valid=%b required 0 pending, out_valid=0", q6.size(), b6.out_valid);
        end
    endtask

    task automatic drain3();
        int n = 0;
        while ((q3.size() != 0 || b3.out_valid !== 1'b0) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (q3.size() != 0 || b3.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain3 got %0d pending, out_valid=%b required 0 pending, out_valid=0", q3.size(), b3.out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr6 = 1'b0; clr3 = 1'b0;
        b6.out_ready = 1'b1; b6.in_valid = 1'b1; b6.in_bit = 1'b0;
        b3.out_ready = 1'b1; b3.in_valid = 1'b0; b3.in_bit = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({b6.out_valid, b6.out_bit, b6.out_stuff} !== 3'b000 || cnt6 !== 16'd0) begin
            failures++;
            $display("FAIL reset_outputs got valid,bit,stuff=%b count=%0d required 000 count=0",
                     {b6.out_valid, b6.out_bit, b6.out_stuff}, cnt6);
        end
        checks++;
        if ({b3.out_valid, b3.out_bit, b3.out_stuff} !== 3'b000 || cnt3 !== 16'd0) begin
            failures++;
            $display("FAIL reset_outputs3 got valid,bit,stuff=%b count=%0d required 000 count=0",
                     {b3.out_valid, b3.out_bit, b3.out_stuff}, cnt3);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (b6.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got %b required 1", b6.in_ready);
        end
        model6(1'b0);
        @(posedge clk);
        #1;
        b6.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (b6.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_accept got out_valid=%b required 1", b6.out_valid);
        end
        drain6();
    endtask

    task automatic test_basic_run();
        logic [7:0] bits = 8'b1111_1110;
        int st, st7 = 0, total = 0, o0 = outs6;
        for (int i = 0; i < 8; i++) begin
            send6(bits[7-i], st);
            total += st;
            if (i == 6) st7 = st;
        end
        checks++;
        if (st7 !== 1 || total !== 1) begin
            failures++;
            $display("FAIL basic_stall got 7th=%0d total=%0d required 1 and 1", st7, total);
        end
        drain6();
        checks++;
        if (outs6 - o0 !== 9) begin
            failures++;
            $display("FAIL basic_length got %0d required 9", outs6 - o0);
        end
        checks++;
        if (cnt6 !== 16'(CNT_EN ? stuffs6 : 0)) begin
            failures++;
            $display("FAIL basic_count got %0d required %0d", cnt6, CNT_EN ? stuffs6 : 0);
        end
    endtask

    task automatic test_run_reset_by_zero();
        logic [11:0] bits = 12'b1111_1011_1111;
        int st, total = 0, o0 = outs6;
        for (int i = 0; i < 12; i++) begin
            send6(bits[11-i], st);
            total += st;
        end
        drain6();
        checks++;
        if (outs6 - o0 !== 13 || total !== 0) begin
            failures++;
            $display("FAIL zero_reset_length got len=%0d stall=%0d required len=13 stall=0", outs6 - o0, total);
        end
        checks++;
        if (cnt6 !== 16'(CNT_EN ? stuffs6 : 0)) begin
            failures++;
            $display("FAIL zero_reset_count got %0d required %0d", cnt6, CNT_EN ? stuffs6 : 0);
        end
    endtask

    task automatic test_backpressure();
        int st, o0 = outs6;
        for (int i = 0; i < 6; i++) send6(1'b1, st);
        b6.out_ready = 1'b0;
        b6.in_bit    = 1'b0;
        b6.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({b6.out_valid, b6.out_bit, b6.out_stuff, b6.in_ready} !== 4'b1100) begin
                failures++;
                $display("FAIL bp_hold cycle %0d got valid,bit,stuff,in_ready=%b required 1100", i,
                         {b6.out_valid, b6.out_bit, b6.out_stuff, b6.in_ready});
            end
            @(posedge clk);
            #1;
        end
        b6.out_ready = 1'b1;
        send6(1'b0, st);
        checks++;
        if (st !== 1) begin
            failures++;
            $display("FAIL bp_release_stall got %0d required 1", st);
        end
        drain6();
        checks++;
        if (outs6 - o0 !== 8) begin
            failures++;
            $display("FAIL bp_length got %0d required 8", outs6 - o0);
        end
    endtask

    task automatic test_clr();
        int st, o0 = outs6;
        for (int i = 0; i < 5; i++) send6(1'b1, st);
        clr6 = 1'b1;
        b6.in_bit = 1'b1;
        b6.in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (b6.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL clr_in_ready got %b required 0", b6.in_ready);
        end
        run6 = 0;
        stuffs6 = 0;
        @(posedge clk);
        #1;
        clr6 = 1'b0;
        b6.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cnt6 !== 16'd0) begin
            failures++;
            $display("FAIL clr_count got %0d required 0", cnt6);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) send6(1'b1, st);
        send6(1'b0, st);
        drain6();
        checks++;
        if (outs6 - o0 !== 11) begin
            failures++;
            $display("FAIL clr_length got %0d required 11", outs6 - o0);
        end
    endtask

    task automatic test_run3();
        int st, total = 0, o0 = outs3;
        for (int i = 0; i < 9; i++) begin
            send3(1'b1, st);
            total += st;
        end
        drain3();
        checks++;
        if (outs3 - o0 !== 12 || total !== 2) begin
            failures++;
            $display("FAIL run3_length got len=%0d stall=%0d required len=12 stall=2", outs3 - o0, total);
        end
        checks++;
        if (cnt3 !== 16'(CNT_EN ? 3 : 0)) begin
            failures++;
            $display("FAIL run3_count got %0d required %0d", cnt3, CNT_EN ? 3 : 0);
        end
    endtask

    task automatic test_reset_mid_stuff();
        int st, o0;
        for (int i = 0; i < 6; i++) send6(1'b1, st);
        b6.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (b6.out_valid !== 1'b0 || cnt6 !== 16'd0) begin
            failures++;
            $display("FAIL midreset_clear got out_valid=%b count=%0d required 0 and 0", b6.out_valid, cnt6);
        end
        q6.delete();
        run6 = 0;
        stuffs6 = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        b6.out_ready = 1'b1;
        o0 = outs6;
        send6(1'b1, st);
        send6(1'b0, st);
        drain6();
        checks++;
        if (outs6 - o0 !== 2) begin
            failures++;
            $display("FAIL midreset_length got %0d required 2", outs6 - o0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_run_reset_by_zero();
        test_backpressure();
        test_clr();
        test_run3();
        test_reset_mid_stuff();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_bit_stuffer_hs.md
# usb_bit_stuffer_hs

Parametrised NRZI-precursor bit stuffer with valid/ready handshaking on both sides. Sits between the TX serialiser and the NRZI encoder. After every run of MAX_RUN consecutive ones it inserts one zero and backpressures the serialiser for that cycle. It supersedes the fixed-run, handshake-less stuffer: no bit is ever dropped, and the downstream encoder may stall.

## Interface
- MAX_RUN, 6: consecutive ones that trigger a stuffed zero; legal range 2..15.
- CNT_W, 16: width of the stuff-event counter.
- clk  in  1  sole clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous packet-boundary clear of run tracking.
- in_bit  in  1  data bit from serialiser.
- in_valid  in  1  in_bit valid.
- in_ready  out  1  block accepts in_bit this cycle.
- out_bit  out  1  stuffed bitstream bit.
- out_valid  out  1  out_bit valid.
- out_ready  in  1  downstream accepts out_bit this cycle.
- out_stuff  out  1  current out_bit is an inserted stuff bit.
- stuff_count  out  CNT_W  saturating count of inserted stuff bits.

## Operation
- Single output register holds out_bit, out_valid and out_stuff. The slot is free when !out_valid || out_ready.
- The FSM has two states:
  - RUN: in_ready = slot free && !clr.
  - STUFF: in_ready = 0.
- Run counter run_cnt is $clog2(MAX_RUN+1) bits wide.
- In RUN, an input accept (in_valid && in_ready):
  - Loads out_bit=in_bit, out_valid=1, out_stuff=0.
  - in_bit=1: run_cnt+1. If the result equals MAX_RUN, run_cnt←0 and the FSM moves to STUFF.
  - in_bit=0: run_cnt←0.
- In RUN with slot free and no accept: out_valid←0.
- In STUFF with slot free:
  - Loads out_bit=0, out_valid=1, out_stuff=1.
  - Increments stuff_count; it saturates at all-ones.
  - FSM moves to RUN.
- In STUFF with slot not free: hold everything. The stuff bit is never skipped, so a stuffed zero follows the final run of MAX_RUN ones even if no further input arrives.
- clr:
  - run_cnt←0 and FSM←RUN, discarding any pending stuff.
  - The output register completes its normal handshake.
  - No input is accepted that cycle.
  - clr outranks the STUFF transition and the run_cnt update.
- Output register contents are stable while out_valid && !out_ready.

## Timing
- Reset values:
  - out_bit=0, out_valid=0, out_stuff=0, stuff_count=0.
  - run_cnt=0, FSM=RUN.
  - in_ready=1 once RST deasserts, given clr=0.
- Latency: in_bit accepted at edge N appears on out_bit after edge N, i.e. in cycle N+1.
- in_ready is combinational from FSM state, out_valid, out_ready and clr. There is no combinational path from in_valid or in_bit.
- Sustained throughput: 1 bit/cycle, minus exactly 1 cycle per inserted stuff bit.
- The stuffed zero occupies the cycle immediately after the MAX_RUN-th one when out_ready=1.
- RST asserted mid-STUFF or mid-run: the pending stuff bit and run history are lost, and outputs clear immediately.

## Configuration
- USB_BIT_STUFFER_CNT_EN defined: stuff_count is implemented as specified, and clr also zeroes it.
- USB_BIT_STUFFER_CNT_EN undefined: no counter logic; stuff_count is tied to 0. All other behaviour is identical.

## Test plan
- Reset: assert RST with out_ready=1 and in_valid=1. Required: out_valid=0, out_bit=0, stuff_count=0. First edge after release accepts a bit.
- MAX_RUN=6, out_ready=1, input 1,1,1,1,1,1,1,0:
  - Output 1,1,1,1,1,1,0(stuff),1,0.
  - in_ready=0 for exactly one cycle after the 6th accept.
  - out_stuff high only on the inserted 0; stuff_count=1.
- Input 1,1,1,1,1,0,1,1,1,1,1,1:
  - The 0 resets the run, so exactly one stuff bit appears, after the final six ones.
  - Output length 13.
- Backpressure: with the stuff bit pending, hold out_ready=0 for 4 cycles.
  - The 6th one stays on out_bit.
  - in_ready stays 0 and the stuff bit is emitted after release.
  - Exactly one zero is inserted, and no input bit is lost or duplicated.
- clr: after 5 ones, pulse clr, then send 1. Required: no stuff bit, run restarts at 1. With the macro defined, stuff_count clears to 0.
- MAX_RUN=3 instance with input all ones, 9 bits, out_ready=1: output 1,1,1,0,1,1,1,0,1,1,1,0; stuff_count=3.
